// File: rtl/btn_autorepeat.sv
`default_nettype none
// ============================================================================
//  Module   : btn_autorepeat
//  Purpose  : Button conditioning for the game control block. Each channel
//             runs a 2-flop synchroniser, a debounce filter and a delayed
//             auto-repeat FSM (initial delay, then fixed-rate repeats). The
//             result is clean one-cycle command pulses in the game clock
//             domain.
//  Ports    : clk         - 50 MHz game clock
//             reset_n     - asynchronous active-low reset
//             btn_raw     - raw asynchronous button levels, 1 = pressed
//             clr         - synchronous suppress (game start / game over)
//             btn_level   - debounced button level
//             btn_press   - 1-cycle pulse per accepted press and per repeat
//             btn_release - 1-cycle pulse on debounced release
//  Options  : BTN_RELEASE_EVT_EN - when defined, btn_release is generated;
//             otherwise btn_release is tied low and no release logic exists.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_autorepeat #(
  parameter int               N_BTN        = 4,
  parameter int               DEBOUNCE_CYC = 500000,
  parameter int               DAS_CYC      = 8500000,
  parameter int               ARR_CYC      = 2500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = 4'b0111
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Counter widths: clog2 of the terminal count, never narrower than 1 bit.
  localparam int c_db_w  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int c_das_w = (DAS_CYC > 1) ? $clog2(DAS_CYC) : 1;
  localparam int c_arr_w = (ARR_CYC > 1) ? $clog2(ARR_CYC) : 1;
  // One repeat counter serves both DELAY and REPEAT, so it is sized for the larger.
  localparam int c_rp_w  = (c_das_w > c_arr_w) ? c_das_w : c_arr_w;

  localparam logic [c_db_w-1:0] c_db_last  = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [c_rp_w-1:0] c_das_last = c_rp_w'(DAS_CYC - 1);
  localparam logic [c_rp_w-1:0] c_arr_last = c_rp_w'(ARR_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic              r_press;
    logic [c_db_w-1:0] r_db_cnt;
    logic [c_rp_w-1:0] r_rp_cnt;
    state_t            r_state;

    logic w_mismatch;
    logic w_db_done;
    logic w_rise;
    logic w_fall;
    logic w_level_nxt;

    // The level toggles on the edge that sees the last mismatched count, so a
    // clean step reaches btn_level 2 + DEBOUNCE_CYC edges after it happens.
    assign w_mismatch  = (r_sync2 != r_level);
    assign w_db_done   = w_mismatch && (r_db_cnt == c_db_last);
    assign w_rise      = w_db_done && !r_level;
    assign w_fall      = w_db_done && r_level;
    assign w_level_nxt = r_level ^ w_db_done;

`ifdef BTN_RELEASE_EVT_EN
    logic r_release;
    assign btn_release[i] = r_release;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_db_cnt  <= '0;
        r_rp_cnt  <= '0;
        r_state   <= ST_IDLE;
`ifdef BTN_RELEASE_EVT_EN
        r_release <= 1'b0;
`endif
      end else begin
        r_sync1 <= btn_raw[i];
        r_sync2 <= r_sync1;

        if (!w_mismatch || w_db_done) begin
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_db_w'(1);
        end
        r_level <= w_level_nxt;

        r_press <= 1'b0;
`ifdef BTN_RELEASE_EVT_EN
        r_release <= w_fall && !clr;
`endif

        if (clr) begin
          // Park a held button in HOLD so it stays silent until re-pressed.
          r_state  <= w_level_nxt ? ST_HOLD : ST_IDLE;
          r_rp_cnt <= '0;
        end else if (w_fall) begin
          // Release beats any repeat due on the same edge.
          r_state  <= ST_IDLE;
          r_rp_cnt <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_rp_cnt <= '0;
              if (w_rise) begin
                r_press <= 1'b1;
                r_state <= REPEAT_MASK[i] ? ST_DELAY : ST_HOLD;
              end
            end
            ST_DELAY: begin
              if (r_rp_cnt == c_das_last) begin
                r_press  <= 1'b1;
                r_state  <= ST_REPEAT;
                r_rp_cnt <= '0;
              end else begin
                r_rp_cnt <= r_rp_cnt + c_rp_w'(1);
              end
            end
            ST_REPEAT: begin
              if (r_rp_cnt == c_arr_last) begin
                r_press  <= 1'b1;
                r_rp_cnt <= '0;
              end else begin
                r_rp_cnt <= r_rp_cnt + c_rp_w'(1);
              end
            end
            default: begin
              r_rp_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[i] = r_level;
    assign btn_press[i] = r_press;
  end

`ifndef BTN_RELEASE_EVT_EN
  assign btn_release = '0;
`endif

endmodule
`default_nettype wire
